// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the pipelined RV32 core: program counter, imem address,
// and the IF/ID register that hands the fetched instruction, its PC and PC+4 to decode.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]           NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic [31:0]           InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [31:0]           InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PC_PlusD,
  output logic                  ValidD,
  output logic [31:0]           FetchCount
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] target_aligned;
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  load_d;

  // Redirect targets are word-aligned by construction; the two low bits are discarded.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^PCTargetE[1:0];

  // Plain modular add: 0xFFFF_FFFC + 4 wraps to 0.
  assign pc_plus4       = PCF + PC_STEP;
  assign target_aligned = {PCTargetE[DATA_WIDTH-1:2], 2'b00};

  // A resolved redirect wins over a fetch stall; reset is handled in the register.
  always_comb begin
    pc_next = pc_plus4;
    if (PCSrcE) begin
      pc_next = target_aligned;
    end else if (StallF) begin
      pc_next = PCF;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let PCF's new value leak into PCD.
  always_ff @(posedge clk) begin
    if (rst) begin
      PCF <= RESET_PC;
    end else begin
      PCF <= pc_next;
    end
  end

  // Flush beats stall; the accepted-instruction counter follows the load path only.
  assign load_d = !rst && !FlushD && !StallD;

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PC_PlusD <= '0;
      ValidD   <= 1'b0;
    end else if (load_d) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PC_PlusD <= pc_plus4;
      ValidD   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      FetchCount <= '0;
    end else if (load_d) begin
      FetchCount <= FetchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized control traffic compared every cycle against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall_f, stall_d, flush_d, pc_src;
  logic [31:0] pc_target;
  logic [31:0] instr_f, pcf, instr_d, pcd, pc_plus_d, fetch_count;
  logic        valid_d;

  // Second instance starting at the top of the address space to exercise PC wrap.
  logic [31:0] w_instr_f, w_pcf, w_instr_d, w_pcd, w_pc_plus_d, w_fetch_count;
  logic        w_valid_d;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: word i holds i+1.
  function automatic logic [31:0] imem(input logic [31:0] addr);
    return (addr >> 2) + 32'd1;
  endfunction

  assign instr_f   = imem(pcf);
  assign w_instr_f = imem(w_pcf);

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(32'h13)) dut (
    .clk(clk), .rst(rst), .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d),
    .PCSrcE(pc_src), .PCTargetE(pc_target), .InstrF(instr_f), .PCF(pcf),
    .InstrD(instr_d), .PCD(pcd), .PC_PlusD(pc_plus_d), .ValidD(valid_d),
    .FetchCount(fetch_count)
  );

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h13)) dut_wrap (
    .clk(clk), .rst(rst), .StallF(1'b0), .StallD(1'b0), .FlushD(1'b0),
    .PCSrcE(1'b0), .PCTargetE(32'h0), .InstrF(w_instr_f), .PCF(w_pcf),
    .InstrD(w_instr_d), .PCD(w_pcd), .PC_PlusD(w_pc_plus_d), .ValidD(w_valid_d),
    .FetchCount(w_fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the architectural effect of each edge, from the stage's rules.
  logic [31:0] m_pc, m_instr, m_pcd, m_plus, m_count;
  logic        m_valid;
  bit          model_valid = 0;

  always @(posedge clk) begin
    logic [31:0] next_pc;
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_plus = 0; m_valid = 0; m_count = 0;
      model_valid = 1;
    end else if (model_valid) begin
      if (pc_src)       next_pc = pc_target & ~32'h3;
      else if (stall_f) next_pc = m_pc;
      else              next_pc = m_pc + 32'd4;
      if (flush_d) begin
        m_instr = 32'h13; m_pcd = 0; m_plus = 0; m_valid = 0;
      end else if (!stall_d) begin
        m_instr = imem(m_pc); m_pcd = m_pc; m_plus = m_pc + 32'd4; m_valid = 1;
        m_count = m_count + 32'd1;
      end
      m_pc = next_pc;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_pcf",    pcf,         m_pc);
      check("model_instrd", instr_d,     m_instr);
      check("model_pcd",    pcd,         m_pcd);
      check("model_plusd",  pc_plus_d,   m_plus);
      check("model_validd", {31'b0, valid_d}, {31'b0, m_valid});
      check("model_count",  fetch_count, m_count);
    end
  end

  // Apply one cycle of inputs (aligned to the falling edge) and return after the next one.
  task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic ps, input logic [31:0] tg);
    rst = r; stall_f = sf; stall_d = sd; flush_d = fd; pc_src = ps; pc_target = tg;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pcf"},    pcf,         32'h0);
    check({tag, "_instrd"}, instr_d,     32'h13);
    check({tag, "_pcd"},    pcd,         32'h0);
    check({tag, "_plusd"},  pc_plus_d,   32'h0);
    check({tag, "_validd"}, {31'b0, valid_d}, 32'h0);
    check({tag, "_count"},  fetch_count, 32'h0);
  endtask

  initial begin
    rst = 1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src = 0; pc_target = 0;
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 32'h0);
    check_reset_values("reset");
    check("wrap_reset_pcf", w_pcf, 32'hFFFF_FFFC);

    // Free run from reset, including the wrap instance's first edge.
    run(1);
    check("wrap_pcf",   w_pcf,       32'h0);
    check("wrap_pcd",   w_pcd,       32'hFFFF_FFFC);
    check("wrap_plusd", w_pc_plus_d, 32'h0);
    run(3);
    check("run4_pcf",    pcf,         32'h10);
    check("run4_instrd", instr_d,     32'h4);
    check("run4_pcd",    pcd,         32'hC);
    check("run4_plusd",  pc_plus_d,   32'h10);
    check("run4_validd", {31'b0, valid_d}, 32'h1);
    check("run4_count",  fetch_count, 32'h4);

    // Full stall at PCF=0x8 for three cycles, then resume without gaps.
    drive(1, 0, 0, 0, 0, 32'h0);
    run(2);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 32'h0);
      check("stall_pcf",    pcf,         32'h8);
      check("stall_instrd", instr_d,     32'h2);
      check("stall_pcd",    pcd,         32'h4);
      check("stall_count",  fetch_count, 32'h2);
    end
    run(1);
    check("resume_pcd0",   pcd,         32'h8);
    check("resume_instr0", instr_d,     32'h3);
    check("resume_count0", fetch_count, 32'h3);
    run(1);
    check("resume_pcd1",   pcd,         32'hC);
    check("resume_count1", fetch_count, 32'h4);

    // Redirect with flush at PCF=0x20.
    run(4);
    check("pre_redirect_pcf", pcf, 32'h20);
    drive(0, 0, 0, 1, 1, 32'h103);
    check("redir_pcf",    pcf,         32'h100);
    check("redir_instrd", instr_d,     32'h13);
    check("redir_pcd",    pcd,         32'h0);
    check("redir_validd", {31'b0, valid_d}, 32'h0);
    check("redir_count",  fetch_count, 32'h8);
    run(1);
    check("target_pcd",    pcd,     32'h100);
    check("target_validd", {31'b0, valid_d}, 32'h1);
    check("target_instrd", instr_d, 32'h41);

    // Priority: redirect beats fetch stall; flush beats decode stall.
    drive(0, 1, 0, 0, 1, 32'h200);
    check("prio_redirect_pcf", pcf, 32'h200);
    drive(0, 0, 1, 1, 0, 32'h0);
    check("prio_flush_validd", {31'b0, valid_d}, 32'h0);
    check("prio_flush_instrd", instr_d, 32'h13);

    // Reset asserted in the middle of a stall.
    drive(0, 1, 1, 0, 0, 32'h0);
    drive(1, 1, 1, 0, 0, 32'h0);
    check_reset_values("midrst");

    // Randomized control traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(63) == 0,
            $urandom_range(3) == 0,
            $urandom_range(3) == 0,
            $urandom_range(7) == 0,
            $urandom_range(7) == 0,
            $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
